// File: rtl/layer_mac_array_if.sv
// Stream bundle for layer_mac_array: x elements in, y elements (with saturation flag) out.
interface layer_mac_array_if #(parameter int T = 16) ();
    logic         s_valid;
    logic         s_ready;
    logic [T-1:0] data_in;
    logic         m_valid;
    logic         m_ready;
    logic [T-1:0] data_out;
    logic         sat;

    modport master (output s_valid, data_in, m_ready,
                    input  s_ready, m_valid, data_out, sat);
    modport slave  (input  s_valid, data_in, m_ready,
                    output s_ready, m_valid, data_out, sat);
endinterface

// File: rtl/layer_mac_array.sv
// Fully-connected layer y = act(sat((W*x + b) >>> FRAC)); P lanes compute P rows per pass.
// W and b come from external 1-cycle-latency ROMs; x and y stream over valid/ready.
module layer_mac_array #(
    parameter int M    = 8,
    parameter int N    = 4,
    parameter int P    = 2,
    parameter int T    = 16,
    parameter int FRAC = 0,
    parameter int RELU = 1,
    localparam int WAW = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int BAW = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             reset,
    layer_mac_array_if.slave bus,
    output logic [P*WAW-1:0] w_addr,
    input  logic [P*T-1:0]   w_data,
    output logic [P*BAW-1:0] b_addr,
    input  logic [P*T-1:0]   b_data
);
    localparam int ACC    = 2 * T + $clog2(N) + 1;
    localparam int XW     = (N > 1) ? $clog2(N) : 1;
    localparam int CW     = $clog2(N + 3);
    localparam int PASSES = M / P;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int OW     = (P > 1) ? $clog2(P) : 1;
    localparam logic signed [T-1:0] SAT_MAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] SAT_MIN = {1'b1, {(T-1){1'b0}}};

    if (M % P != 0) begin : g_bad_lane_count
        $error("layer_mac_array: M must be a multiple of P");
    end

    typedef enum logic [1:0] {GET_X, COMPUTE, OUTPUT} state_t;

    state_t                  state, next_state;
    logic [XW-1:0]           x_cnt;
    logic [CW-1:0]           cyc_cnt;
    logic [PW-1:0]           pass_cnt;
    logic [OW-1:0]           o_cnt;
    logic signed [T-1:0]     x_mem     [1<<XW];
    logic signed [T-1:0]     x_q;
    logic signed [2*T-1:0]   prod      [P];
    logic signed [ACC-1:0]   acc       [P];
    logic signed [ACC-1:0]   shifted   [P];
    logic signed [T-1:0]     res_data  [P];
    logic                    res_sat   [P];
    logic signed [T-1:0]     obuf_data [1<<OW];
    logic                    obuf_sat  [1<<OW];

    logic x_fire, y_fire, last_x, last_o, last_pass, comp_done;

    assign x_fire    = (state == GET_X) && bus.s_valid;
    assign y_fire    = (state == OUTPUT) && bus.m_ready;
    assign last_x    = (x_cnt == XW'(N - 1));
    assign last_o    = (o_cnt == OW'(P - 1));
    assign last_pass = (pass_cnt == PW'(PASSES - 1));
    assign comp_done = (cyc_cnt == CW'(N + 2));

    assign bus.s_ready  = (state == GET_X);
    assign bus.m_valid  = (state == OUTPUT);
    assign bus.data_out = (state == OUTPUT) ? obuf_data[o_cnt] : '0;
    assign bus.sat      = (state == OUTPUT) && obuf_sat[o_cnt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= GET_X;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            GET_X:   if (x_fire && last_x) next_state = COMPUTE;
            COMPUTE: if (comp_done) next_state = OUTPUT;
            OUTPUT:  if (y_fire && last_o) next_state = last_pass ? GET_X : COMPUTE;
            default: next_state = GET_X;
        endcase
    end

    // Lane l works on row pass*P+l; weight addresses walk j=0..N-1 during the first N compute cycles.
    always_comb begin
        w_addr = '0;
        b_addr = '0;
        if (state == COMPUTE) begin
            for (int l = 0; l < P; l++) begin
                b_addr[l*BAW +: BAW] = BAW'(int'(pass_cnt) * P + l);
                if (cyc_cnt < CW'(N))
                    w_addr[l*WAW +: WAW] = WAW'((int'(pass_cnt) * P + l) * N + int'(cyc_cnt));
            end
        end
    end

    // Saturation is judged on the shifted value; RELU clamps afterwards so sat survives a zeroed result.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            shifted[l] = acc[l] >>> FRAC;
            res_sat[l] = !((&shifted[l][ACC-1:T-1]) || !(|shifted[l][ACC-1:T-1]));
            if (res_sat[l]) res_data[l] = shifted[l][ACC-1] ? SAT_MIN : SAT_MAX;
            else            res_data[l] = shifted[l][T-1:0];
            if (RELU != 0 && res_data[l][T-1]) res_data[l] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt    <= '0;
            cyc_cnt  <= '0;
            pass_cnt <= '0;
            o_cnt    <= '0;
            x_q      <= '0;
            for (int i = 0; i < (1 << XW); i++) x_mem[i] <= '0;
            for (int l = 0; l < P; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
            end
            for (int i = 0; i < (1 << OW); i++) begin
                obuf_data[i] <= '0;
                obuf_sat[i]  <= 1'b0;
            end
        end else begin
            case (state)
                GET_X: begin
                    cyc_cnt <= '0;
                    o_cnt   <= '0;
                    if (x_fire) begin
                        x_mem[x_cnt] <= bus.data_in;
                        x_cnt        <= last_x ? '0 : x_cnt + XW'(1);
                    end
                end
                // Cycle k issues address j=k; x/ROM data land at k+1, product at k+2, accumulate at k+3.
                COMPUTE: begin
                    cyc_cnt <= comp_done ? '0 : cyc_cnt + CW'(1);
                    if (cyc_cnt < CW'(N)) x_q <= x_mem[XW'(cyc_cnt)];
                    for (int l = 0; l < P; l++) begin
                        if (cyc_cnt >= CW'(1) && cyc_cnt <= CW'(N))
                            prod[l] <= $signed(w_data[l*T +: T]) * x_q;
                        if (cyc_cnt == CW'(1))
                            acc[l] <= ACC'($signed(b_data[l*T +: T])) <<< FRAC;
                        else if (cyc_cnt >= CW'(2) && cyc_cnt <= CW'(N + 1))
                            acc[l] <= acc[l] + ACC'(prod[l]);
                        if (comp_done) begin
                            obuf_data[l] <= res_data[l];
                            obuf_sat[l]  <= res_sat[l];
                        end
                    end
                end
                OUTPUT: begin
                    if (y_fire) begin
                        o_cnt <= last_o ? '0 : o_cnt + OW'(1);
                        if (last_o) pass_cnt <= last_pass ? '0 : pass_cnt + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_mac_array.sv
// Directed bench for layer_mac_array: a default 2-lane RELU instance and a 1-lane FRAC=4 signed instance.
module tb_layer_mac_array;
    localparam int T = 16;
    localparam int M = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit              sel;
    logic            drv_s_valid, drv_m_ready;
    logic [T-1:0]    drv_data;
    logic            obs_s_ready, obs_m_valid, obs_sat;
    logic signed [T-1:0] obs_data;

    layer_mac_array_if #(.T(T)) bus0 ();
    layer_mac_array_if #(.T(T)) bus1 ();

    assign bus0.s_valid = drv_s_valid & ~sel;
    assign bus1.s_valid = drv_s_valid & sel;
    assign bus0.data_in = drv_data;
    assign bus1.data_in = drv_data;
    assign bus0.m_ready = drv_m_ready & ~sel;
    assign bus1.m_ready = drv_m_ready & sel;
    assign obs_s_ready  = sel ? bus1.s_ready  : bus0.s_ready;
    assign obs_m_valid  = sel ? bus1.m_valid  : bus0.m_valid;
    assign obs_data     = sel ? bus1.data_out : bus0.data_out;
    assign obs_sat      = sel ? bus1.sat      : bus0.sat;

    logic [9:0]  w_addr0;
    logic [31:0] w_data0;
    logic [5:0]  b_addr0;
    logic [31:0] b_data0;
    logic [4:0]  w_addr1;
    logic [15:0] w_data1;
    logic [2:0]  b_addr1;
    logic [15:0] b_data1;

    layer_mac_array #(.M(8), .N(4), .P(2), .T(16), .FRAC(0), .RELU(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0)
    );

    layer_mac_array #(.M(8), .N(4), .P(1), .T(16), .FRAC(4), .RELU(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1)
    );

    logic signed [T-1:0] w_rom [M*N];
    logic signed [T-1:0] b_rom [M];

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            w_data0[l*16 +: 16] <= w_rom[w_addr0[l*5 +: 5]];
            b_data0[l*16 +: 16] <= b_rom[b_addr0[l*3 +: 3]];
        end
        w_data1 <= w_rom[w_addr1];
        b_data1 <= b_rom[b_addr1];
    end

    logic signed [T-1:0] got_data [M];
    logic                got_sat  [M];
    int n_got, hs_cyc, first_valid_cyc;
    bit sready_seen;

    task automatic set_row(input int r, input int a, input int b, input int c, input int d, input int bias);
        w_rom[r*N+0] = T'(a);
        w_rom[r*N+1] = T'(b);
        w_rom[r*N+2] = T'(c);
        w_rom[r*N+3] = T'(d);
        b_rom[r]     = T'(bias);
    endtask

    task automatic load_rom_default();
        set_row(0,  51, -79, -116,    8, -54);
        set_row(1, -60, -23,   61,   78,  45);
        set_row(2,   1,   2,    3,    4,  10);
        set_row(3,  -1,   0,    2,    5,  -3);
        set_row(4, 100, -50,   25,   10,   7);
        set_row(5,  -7,  -7,   -7,   -7, 100);
        set_row(6,   3,  -2,    1,    0, -20);
        set_row(7,   0,   0,    0, 1000,  -1);
    endtask

    task automatic applyStimulus_unused_guard();
    endtask

    task automatic send_x(input int a, input int b, input int c, input int d);
        int xs[4];
        bit ok;
        int guard;
        xs = '{a, b, c, d};
        for (int i = 0; i < N; i++) begin
            drv_data    = T'(xs[i]);
            drv_s_valid = 1'b1;
            guard       = 0;
            forever begin
                ok = obs_s_ready;
                if (ok) hs_cyc = cyc;
                @(posedge clk); #1;
                if (ok) break;
                guard++;
                if (guard > 300) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL send_x_timeout: element %0d s_ready=0 for %0d cycles, required 1", i, guard);
                    break;
                end
            end
        end
        drv_s_valid = 1'b0;
    endtask

    task automatic collect(input int nbeats, input bit toggle);
        bit [3:0] pat = 4'b1001;
        int k = 0;
        int guard = 0;
        bit holding = 0;
        bit rdy;
        logic signed [T-1:0] held_d;
        logic held_s;
        n_got = 0;
        sready_seen = 0;
        first_valid_cyc = -1;
        for (int i = 0; i < M; i++) begin
            got_data[i] = 'x;
            got_sat[i]  = 1'bx;
        end
        while (n_got < nbeats && guard < 300) begin
            rdy = toggle ? pat[k % 4] : 1'b1;
            drv_m_ready = rdy;
            if (obs_s_ready) sready_seen = 1;
            if (obs_m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                k++;
                if (holding) begin
                    vectors++;
                    if (obs_data !== held_d || obs_sat !== held_s) begin
                        miscompares++;
                        $display("[TB] FAIL stall_hold: data %0d sat %0b, required %0d sat %0b", obs_data, obs_sat, held_d, held_s);
                    end
                end
                if (rdy) begin
                    got_data[n_got] = obs_data;
                    got_sat[n_got]  = obs_sat;
                    n_got++;
                    holding = 0;
                end else begin
                    holding = 1;
                    held_d  = obs_data;
                    held_s  = obs_sat;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        drv_m_ready = 1'b0;
        if (n_got < nbeats) begin
            vectors++; miscompares++;
            $display("[TB] FAIL collect_timeout: got %0d beats, required %0d", n_got, nbeats);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drv_s_valid = 1'b0; drv_m_ready = 1'b0; drv_data = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus0.s_ready !== 1'b1 || bus1.s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_s_ready: got %0b/%0b, required 1/1", bus0.s_ready, bus1.s_ready);
        end
        vectors++;
        if (bus0.m_valid !== 1'b0 || bus0.data_out !== 16'd0 || bus0.sat !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: m_valid %0b data %0d sat %0b, required 0 0 0", bus0.m_valid, bus0.data_out, bus0.sat);
        end
        vectors++;
        if (w_addr0 !== 10'd0 || b_addr0 !== 6'd0 || w_addr1 !== 5'd0 || b_addr1 !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: w %0d/%0d b %0d/%0d, required all 0", w_addr0, w_addr1, b_addr0, b_addr1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus0.s_ready !== 1'b1 || bus0.m_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: s_ready %0b m_valid %0b, required 1 0", bus0.s_ready, bus0.m_valid);
        end
    endtask

    task automatic test_basic();
        int exp_y [M] = '{0, 434, 40, 22, 122, 30, 0, 3999};
        sel = 1'b0;
        load_rom_default();
        send_x(1, 2, 3, 4);
        collect(M, 1'b0);
        vectors++;
        if (first_valid_cyc - hs_cyc !== N + 4) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: %0d cycles, required %0d", first_valid_cyc - hs_cyc, N + 4);
        end
        for (int i = 0; i < M; i++) begin
            vectors++;
            if (got_data[i] !== T'(exp_y[i]) || got_sat[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL basic_y%0d: got %0d sat %0b, required %0d sat 0", i, got_data[i], got_sat[i], exp_y[i]);
            end
        end
        vectors++;
        if (obs_m_valid !== 1'b0 || obs_s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_beat_count: m_valid %0b s_ready %0b after 8 beats, required 0 1", obs_m_valid, obs_s_ready);
        end
    endtask

    task automatic test_two_lane();
        int exp_y [M] = '{0, 101, 20, 3, 92, 72, 0, 999};
        sel = 1'b0;
        send_x(1, 1, 1, 1);
        collect(M, 1'b0);
        for (int i = 0; i < M; i++) begin
            vectors++;
            if (got_data[i] !== T'(exp_y[i]) || got_sat[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL two_lane_y%0d: got %0d sat %0b, required %0d sat 0", i, got_data[i], got_sat[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int exp_y [M] = '{0, 434, 40, 22, 122, 30, 0, 3999};
        sel = 1'b0;
        send_x(1, 2, 3, 4);
        collect(M, 1'b1);
        for (int i = 0; i < M; i++) begin
            vectors++;
            if (got_data[i] !== T'(exp_y[i]) || got_sat[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure_y%0d: got %0d sat %0b, required %0d sat 0", i, got_data[i], got_sat[i], exp_y[i]);
            end
        end
        vectors++;
        if (sready_seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_s_ready: s_ready seen %0b before 8th beat, required 0", sready_seen);
        end
        vectors++;
        if (obs_s_ready !== 1'b1 || obs_m_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_done: s_ready %0b m_valid %0b, required 1 0", obs_s_ready, obs_m_valid);
        end
    endtask

    task automatic test_saturation();
        int xin [4]  = '{32767, -32768, -32768, 32767};
        int dsel [4] = '{0, 0, 1, 1};
        int exp_v [4] = '{32767, 0, -32768, 32767};
        for (int r = 0; r < M; r++) set_row(r, 32767, 32767, 32767, 32767, 0);
        for (int t = 0; t < 4; t++) begin
            sel = dsel[t][0];
            send_x(xin[t], xin[t], xin[t], xin[t]);
            collect(M, 1'b0);
            for (int i = 0; i < M; i++) begin
                vectors++;
                if (got_data[i] !== T'(exp_v[t]) || got_sat[i] !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL saturation_case%0d_y%0d: got %0d sat %0b, required %0d sat 1", t, i, got_data[i], got_sat[i], exp_v[t]);
                end
            end
        end
    endtask

    task automatic test_frac_shift();
        int exp_y [M] = '{-48, 5, -3, 0, 0, 0, 0, 0};
        sel = 1'b1;
        for (int r = 0; r < M; r++) set_row(r, 0, 0, 0, 0, 0);
        set_row(0, 16, 0, 0, 0, 0);
        set_row(1,  0, 0, 0, 0, 5);
        set_row(2,  1, 0, 0, 0, 0);
        send_x(-48, 0, 0, 0);
        collect(M, 1'b0);
        for (int i = 0; i < M; i++) begin
            vectors++;
            if (got_data[i] !== T'(exp_y[i]) || got_sat[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL frac_shift_y%0d: got %0d sat %0b, required %0d sat 0", i, got_data[i], got_sat[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_reset_midway();
        int exp_y [M] = '{0, 101, 20, 3, 92, 72, 0, 999};
        bit seen_valid = 0;
        sel = 1'b0;
        load_rom_default();
        send_x(1, 2, 3, 4);
        collect(2, 1'b0);
        vectors++;
        if (got_data[0] !== 16'sd0 || got_data[1] !== 16'sd434) begin
            miscompares++;
            $display("[TB] FAIL midreset_pass0: got %0d %0d, required 0 434", got_data[0], got_data[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_m_valid !== 1'b0 || obs_s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_immediate: m_valid %0b s_ready %0b, required 0 1", obs_m_valid, obs_s_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        vectors++;
        if (obs_m_valid !== 1'b0 || obs_s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_next: m_valid %0b s_ready %0b, required 0 1", obs_m_valid, obs_s_ready);
        end
        repeat (12) begin
            @(posedge clk); #1;
            if (obs_m_valid) seen_valid = 1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_quiet: m_valid seen %0b without new vector, required 0", seen_valid);
        end
        send_x(1, 1, 1, 1);
        collect(M, 1'b0);
        for (int i = 0; i < M; i++) begin
            vectors++;
            if (got_data[i] !== T'(exp_y[i]) || got_sat[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_y%0d: got %0d sat %0b, required %0d sat 0", i, got_data[i], got_sat[i], exp_y[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < M * N; i++) w_rom[i] = '0;
        for (int i = 0; i < M; i++) b_rom[i] = '0;
        test_reset();
        test_basic();
        test_two_lane();
        test_back_pressure();
        test_saturation();
        test_frac_shift();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
